// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings for the timer/stopwatch control block
package timer_pkg;

    localparam int DEFAULT_CW = 32;

    typedef enum logic [1:0] {
        MODE_TIMER           = 2'b00,
        MODE_STOPWATCH       = 2'b01,
        MODE_VIEW_CLOCK_DATE = 2'b10,
        MODE_SET_ALARM       = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CD_IDLE    = 2'b00,
        CD_RUN     = 2'b01,
        CD_PAUSE   = 2'b10,
        CD_RINGING = 2'b11
    } cd_state_e;

    typedef enum logic {
        SW_STOPPED = 1'b0,
        SW_RUNNING = 1'b1
    } sw_state_e;

    // startStop/splitReset only mean something while a counter is on display
    function automatic logic mode_has_buttons(input logic [1:0] m);
        return (m == MODE_TIMER) || (m == MODE_STOPWATCH);
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// rtl/lap_fifo.sv - stopwatch lap buffer, drop-on-full FIFO with synchronous clear
module lap_fifo #(
    parameter int CW        = 32,
    parameter int LAP_DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [CW-1:0]                i_data,
    output logic [CW-1:0]                o_data,
    output logic [$clog2(LAP_DEPTH):0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(LAP_DEPTH);

    logic [CW-1:0] r_mem [LAP_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A pop frees the head slot, so a push into a full buffer still lands when paired with a pop
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy; clear empties the buffer without touching stored data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/timer_mode_controller.sv
// rtl/timer_mode_controller.sv - mode decode, countdown and stopwatch sequencing for the 100 Hz datapath
module timer_mode_controller
    import timer_pkg::*;
#(
    parameter int CW         = DEFAULT_CW,
    parameter int LAP_DEPTH  = 8,
    parameter int RING_TICKS = 3000
) (
    input  logic                         clockSignal,
    input  logic                         resetN,
    input  logic                         tickEnable,
    input  logic                         modePress,
    input  logic                         startStopPress,
    input  logic                         splitResetPress,
    input  logic [CW-1:0]                presetCentis,
    input  logic                         lapRead,
    output logic [1:0]                   mode,
    output logic [CW-1:0]                countdownValue,
    output logic                         countdownRunning,
    output logic [CW-1:0]                stopwatchValue,
    output logic                         stopwatchRunning,
    output logic [CW-1:0]                lapData,
    output logic [$clog2(LAP_DEPTH):0]   lapCount,
    output logic                         lapOverflow,
    output logic                         ringSound
);

    localparam int RING_W = $clog2(RING_TICKS + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TICKS - 1);

    logic [1:0]        r_mode;
    cd_state_e         r_cd_state;
    logic [CW-1:0]     r_cd_value;
    logic              r_cd_running;
    logic              r_ring;
    logic [RING_W-1:0] r_ring_cnt;
    sw_state_e         r_sw_state;
    logic [CW-1:0]     r_sw_value;
    logic              r_sw_running;
    logic              r_lap_overflow;

    logic              w_any_press;
    logic              w_silence;
    logic              w_btn_scope;
    logic              w_ss_act;
    logic              w_sr_act;
    logic              w_mode_act;
    logic              w_cd_ss;
    logic              w_cd_sr;
    logic              w_sw_ss;
    logic              w_sw_sr;
    logic              w_lap_push;
    logic              w_lap_clear;
    logic              w_lap_full;
    logic              w_lap_empty;
    logic              w_lap_pop_ok;

    // While ringing, any press is swallowed to silence the alarm and nothing else
    assign w_any_press = modePress || startStopPress || splitResetPress;
    assign w_silence   = r_ring && w_any_press;
    assign w_btn_scope = mode_has_buttons(r_mode);

    // One press acts per cycle: startStop beats splitReset beats mode
    assign w_ss_act    = !w_silence && startStopPress && w_btn_scope;
    assign w_sr_act    = !w_silence && !startStopPress && splitResetPress && w_btn_scope;
    assign w_mode_act  = !w_silence && !startStopPress && !splitResetPress && modePress;

    assign w_cd_ss     = w_ss_act && (r_mode == MODE_TIMER);
    assign w_cd_sr     = w_sr_act && (r_mode == MODE_TIMER);
    assign w_sw_ss     = w_ss_act && (r_mode == MODE_STOPWATCH);
    assign w_sw_sr     = w_sr_act && (r_mode == MODE_STOPWATCH);

    // splitReset means "lap" while running and "clear" while stopped
    assign w_lap_push   = w_sw_sr && (r_sw_state == SW_RUNNING);
    assign w_lap_clear  = w_sw_sr && (r_sw_state == SW_STOPPED);
    assign w_lap_pop_ok = lapRead && !w_lap_empty;

    // Mode selector steps through the four views, wrapping after setAlarm
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            r_mode <= MODE_TIMER;
        end else if (w_mode_act) begin
            r_mode <= r_mode + 2'd1;
        end
    end

    // Countdown FSM; a tick is judged against the pre-edge state, so RUN+startStop+tick still decrements
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            r_cd_state   <= CD_IDLE;
            r_cd_value   <= '0;
            r_cd_running <= 1'b0;
            r_ring       <= 1'b0;
            r_ring_cnt   <= '0;
        end else if (w_silence) begin
            r_cd_state   <= CD_IDLE;
            r_cd_running <= 1'b0;
            r_ring       <= 1'b0;
            r_ring_cnt   <= '0;
        end else begin
            case (r_cd_state)
                CD_IDLE: begin
                    if (w_cd_ss && (presetCentis != '0)) begin
                        r_cd_value   <= presetCentis;
                        r_cd_state   <= CD_RUN;
                        r_cd_running <= 1'b1;
                    end
                end
                CD_RUN: begin
                    if (w_cd_sr) begin
                        r_cd_value   <= '0;
                        r_cd_state   <= CD_IDLE;
                        r_cd_running <= 1'b0;
                    end else if (tickEnable && (r_cd_value == CW'(1))) begin
                        r_cd_value   <= '0;
                        r_cd_state   <= CD_RINGING;
                        r_cd_running <= 1'b0;
                        r_ring       <= 1'b1;
                        r_ring_cnt   <= '0;
                    end else begin
                        if (tickEnable) begin
                            r_cd_value <= r_cd_value - CW'(1);
                        end
                        if (w_cd_ss) begin
                            r_cd_state   <= CD_PAUSE;
                            r_cd_running <= 1'b0;
                        end
                    end
                end
                CD_PAUSE: begin
                    if (w_cd_sr) begin
                        r_cd_value <= '0;
                        r_cd_state <= CD_IDLE;
                    end else if (w_cd_ss) begin
                        r_cd_state   <= CD_RUN;
                        r_cd_running <= 1'b1;
                    end
                end
                CD_RINGING: begin
                    if (tickEnable) begin
                        if (r_ring_cnt == RING_LAST) begin
                            r_cd_state <= CD_IDLE;
                            r_ring     <= 1'b0;
                            r_ring_cnt <= '0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + RING_W'(1);
                        end
                    end
                end
                default: begin
                    r_cd_state   <= CD_IDLE;
                    r_cd_running <= 1'b0;
                    r_ring       <= 1'b0;
                end
            endcase
        end
    end

    // Stopwatch FSM with saturating count and the sticky lap-overflow flag
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            r_sw_state     <= SW_STOPPED;
            r_sw_value     <= '0;
            r_sw_running   <= 1'b0;
            r_lap_overflow <= 1'b0;
        end else begin
            if ((r_sw_state == SW_RUNNING) && tickEnable && (r_sw_value != '1)) begin
                r_sw_value <= r_sw_value + CW'(1);
            end
            if (w_lap_clear) begin
                r_sw_value     <= '0;
                r_lap_overflow <= 1'b0;
            end else if (w_lap_push && w_lap_full && !w_lap_pop_ok) begin
                r_lap_overflow <= 1'b1;
            end
            if (w_sw_ss) begin
                r_sw_state   <= (r_sw_state == SW_RUNNING) ? SW_STOPPED : SW_RUNNING;
                r_sw_running <= (r_sw_state != SW_RUNNING);
            end
        end
    end

    // Laps store the pre-increment value, so a lap on a tick cycle shows the count before that tick
    lap_fifo #(
        .CW        (CW),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .i_clk   (clockSignal),
        .i_rst_n (resetN),
        .i_clear (w_lap_clear),
        .i_push  (w_lap_push),
        .i_pop   (lapRead),
        .i_data  (r_sw_value),
        .o_data  (lapData),
        .o_count (lapCount),
        .o_full  (w_lap_full),
        .o_empty (w_lap_empty)
    );

    assign mode             = r_mode;
    assign countdownValue   = r_cd_value;
    assign countdownRunning = r_cd_running;
    assign ringSound        = r_ring;
    assign stopwatchValue   = r_sw_value;
    assign stopwatchRunning = r_sw_running;
    assign lapOverflow      = r_lap_overflow;

endmodule

// File: tb/tb_timer_mode_controller.sv
// tb/tb_timer_mode_controller.sv - vector table and scoreboard bench for timer_mode_controller
module tb_timer_mode_controller;

    localparam int CW         = 32;
    localparam int LAP_DEPTH  = 8;
    localparam int RING_TICKS = 3000;
    localparam int NW         = $clog2(LAP_DEPTH) + 1;

    localparam logic [4:0] B_NO = 5'b00000;
    localparam logic [4:0] B_MD = 5'b10000;
    localparam logic [4:0] B_SS = 5'b01000;
    localparam logic [4:0] B_SR = 5'b00100;
    localparam logic [4:0] B_TK = 5'b00010;
    localparam logic [4:0] B_RD = 5'b00001;

    logic              clockSignal = 1'b0;
    logic              resetN = 1'b0;
    logic              tickEnable = 1'b0;
    logic              modePress = 1'b0;
    logic              startStopPress = 1'b0;
    logic              splitResetPress = 1'b0;
    logic [CW-1:0]     presetCentis = '0;
    logic              lapRead = 1'b0;
    logic [1:0]        mode;
    logic [CW-1:0]     countdownValue;
    logic              countdownRunning;
    logic [CW-1:0]     stopwatchValue;
    logic              stopwatchRunning;
    logic [CW-1:0]     lapData;
    logic [NW-1:0]     lapCount;
    logic              lapOverflow;
    logic              ringSound;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string         name;
        logic          md, ss, sr, tk, rd;
        logic [CW-1:0] preset;
        logic [1:0]    e_mode;
        logic [CW-1:0] e_cd;
        logic          e_cdr;
        logic [CW-1:0] e_sw;
        logic          e_swr;
        logic [NW-1:0] e_cnt;
        logic          e_ovf;
        logic          e_ring;
        logic [CW-1:0] e_lap;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t sb_q[$];

    timer_mode_controller #(
        .CW         (CW),
        .LAP_DEPTH  (LAP_DEPTH),
        .RING_TICKS (RING_TICKS)
    ) dut (
        .clockSignal      (clockSignal),
        .resetN           (resetN),
        .tickEnable       (tickEnable),
        .modePress        (modePress),
        .startStopPress   (startStopPress),
        .splitResetPress  (splitResetPress),
        .presetCentis     (presetCentis),
        .lapRead          (lapRead),
        .mode             (mode),
        .countdownValue   (countdownValue),
        .countdownRunning (countdownRunning),
        .stopwatchValue   (stopwatchValue),
        .stopwatchRunning (stopwatchRunning),
        .lapData          (lapData),
        .lapCount         (lapCount),
        .lapOverflow      (lapOverflow),
        .ringSound        (ringSound)
    );

    always #5 clockSignal = ~clockSignal;

    function automatic vec_t mk(string n, logic [4:0] b, int unsigned pre, int unsigned md,
                                int unsigned cd, bit cdr, int unsigned sw, bit swr,
                                int unsigned cnt, bit ovf, bit ring, int unsigned lap);
        vec_t v;
        v.name   = n;
        {v.md, v.ss, v.sr, v.tk, v.rd} = b;
        v.preset = CW'(pre);
        v.e_mode = 2'(md);
        v.e_cd   = CW'(cd);
        v.e_cdr  = cdr;
        v.e_sw   = CW'(sw);
        v.e_swr  = swr;
        v.e_cnt  = NW'(cnt);
        v.e_ovf  = ovf;
        v.e_ring = ring;
        v.e_lap  = CW'(lap);
        return v;
    endfunction

    task automatic chk(string n, logic [CW-1:0] act, logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic check_row(vec_t e);
        chk({e.name, ".mode"},  CW'(mode),             CW'(e.e_mode));
        chk({e.name, ".cd"},    countdownValue,        e.e_cd);
        chk({e.name, ".cdrun"}, CW'(countdownRunning), CW'(e.e_cdr));
        chk({e.name, ".sw"},    stopwatchValue,        e.e_sw);
        chk({e.name, ".swrun"}, CW'(stopwatchRunning), CW'(e.e_swr));
        chk({e.name, ".lapcnt"},CW'(lapCount),         CW'(e.e_cnt));
        chk({e.name, ".ovf"},   CW'(lapOverflow),      CW'(e.e_ovf));
        chk({e.name, ".ring"},  CW'(ringSound),        CW'(e.e_ring));
        if (e.e_cnt != '0) begin
            chk({e.name, ".lapdata"}, lapData, e.e_lap);
        end
    endtask

    task automatic check_zero(string n);
        chk({n, ".mode"},    CW'(mode),             '0);
        chk({n, ".cd"},      countdownValue,        '0);
        chk({n, ".cdrun"},   CW'(countdownRunning), '0);
        chk({n, ".sw"},      stopwatchValue,        '0);
        chk({n, ".swrun"},   CW'(stopwatchRunning), '0);
        chk({n, ".lapdata"}, lapData,               '0);
        chk({n, ".lapcnt"},  CW'(lapCount),         '0);
        chk({n, ".ovf"},     CW'(lapOverflow),      '0);
        chk({n, ".ring"},    CW'(ringSound),        '0);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare what the DUT shows after the edge
    task automatic apply(vec_t v);
        vec_t e;
        modePress       = v.md;
        startStopPress  = v.ss;
        splitResetPress = v.sr;
        tickEnable      = v.tk;
        lapRead         = v.rd;
        presetCentis    = v.preset;
        sb_q.push_back(v);
        @(posedge clockSignal);
        #1;
        modePress       = 1'b0;
        startStopPress  = 1'b0;
        splitResetPress = 1'b0;
        tickEnable      = 1'b0;
        lapRead         = 1'b0;
        e = sb_q.pop_front();
        check_row(e);
    endtask

    initial begin
        // Mode walk and a short stopwatch run, interrupted by an asynchronous reset
        tbl_a.push_back(mk("mode1",     B_MD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk("mode2",     B_MD, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk("mode3",     B_MD, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk("mode0",     B_MD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk("mode1b",    B_MD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_a.push_back(mk("sw_go",     B_SS, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl_a.push_back(mk("sw_t1",     B_TK, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl_a.push_back(mk("sw_t2",     B_TK, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0));

        // Countdown to ringing and auto-silence
        tbl_b.push_back(mk("cd_load3",  B_SS, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_t2",     B_TK, 3, 0, 2, 1, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_t1",     B_TK, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_t0",     B_TK, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 1; i <= RING_TICKS; i++)
            tbl_b.push_back(mk($sformatf("ring_t%0d", i), B_TK, 0, 0, 0, 0, 0, 0, 0, 0, (i < RING_TICKS), 0));
        tbl_b.push_back(mk("cd_zero_pre", B_SS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_load100",  B_SS, 100, 0, 100, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 10; i++)
            tbl_b.push_back(mk($sformatf("cd_run%0d", i), B_TK, 0, 0, 100 - i, 1, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_pause",    B_SS, 0, 0, 90, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl_b.push_back(mk($sformatf("cd_hold%0d", i), B_TK, 0, 0, 90, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_resume_tk", B_SS | B_TK, 0, 0, 90, 1, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_pause_tk",  B_SS | B_TK, 0, 0, 89, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("cd_reset",     B_SR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Stopwatch laps, overflow and clear
        tbl_b.push_back(mk("to_sw",     B_MD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("sw_start",  B_SS, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 7; i++)
            tbl_b.push_back(mk($sformatf("sw_tk%0d", i), B_TK, 0, 1, 0, 0, i, 1, 0, 0, 0, 0));
        tbl_b.push_back(mk("lap_on_tick", B_SR | B_TK, 0, 1, 0, 0, 8, 1, 1, 0, 0, 7));
        for (int i = 1; i <= 9; i++)
            tbl_b.push_back(mk($sformatf("lap_more%0d", i), B_SR, 0, 1, 0, 0, 8, 1,
                               (i + 1 > LAP_DEPTH) ? LAP_DEPTH : i + 1, (i + 1 > LAP_DEPTH), 0, 7));
        tbl_b.push_back(mk("sw_stop",   B_SS, 0, 1, 0, 0, 8, 0, 8, 1, 0, 7));
        tbl_b.push_back(mk("sw_clear",  B_SR, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("sw_start2", B_SS, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl_b.push_back(mk("s2_t1",     B_TK, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl_b.push_back(mk("s2_lap1",   B_SR, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1));
        tbl_b.push_back(mk("s2_t2",     B_TK, 0, 1, 0, 0, 2, 1, 1, 0, 0, 1));
        tbl_b.push_back(mk("s2_t3",     B_TK, 0, 1, 0, 0, 3, 1, 1, 0, 0, 1));
        tbl_b.push_back(mk("s2_lap3",   B_SR, 0, 1, 0, 0, 3, 1, 2, 0, 0, 1));
        tbl_b.push_back(mk("s2_t4",     B_TK, 0, 1, 0, 0, 4, 1, 2, 0, 0, 1));
        tbl_b.push_back(mk("s2_lap4",   B_SR, 0, 1, 0, 0, 4, 1, 3, 0, 0, 1));
        tbl_b.push_back(mk("s2_t5",     B_TK, 0, 1, 0, 0, 5, 1, 3, 0, 0, 1));
        tbl_b.push_back(mk("s2_lap5",   B_SR, 0, 1, 0, 0, 5, 1, 4, 0, 0, 1));
        tbl_b.push_back(mk("sw_stop2",  B_SS, 0, 1, 0, 0, 5, 0, 4, 0, 0, 1));
        tbl_b.push_back(mk("rd1",       B_RD, 0, 1, 0, 0, 5, 0, 3, 0, 0, 3));
        tbl_b.push_back(mk("rd2",       B_RD, 0, 1, 0, 0, 5, 0, 2, 0, 0, 4));
        tbl_b.push_back(mk("rd3",       B_RD, 0, 1, 0, 0, 5, 0, 1, 0, 0, 5));
        tbl_b.push_back(mk("rd4",       B_RD, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("rd5_empty", B_RD, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("sw_clear2", B_SR, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("sw_tk_stop",B_TK, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl_b.push_back(mk("sw_start3", B_SS, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < LAP_DEPTH; i++)
            tbl_b.push_back(mk($sformatf("fill%0d", i), B_SR | B_TK, 0, 1, 0, 0, i + 1, 1, i + 1, 0, 0, 0));
        tbl_b.push_back(mk("full_push_pop", B_SR | B_RD, 0, 1, 0, 0, 8, 1, 8, 0, 0, 1));
        tbl_b.push_back(mk("pop_after",     B_RD,        0, 1, 0, 0, 8, 1, 7, 0, 0, 2));

        // Background countdown rings while the stopwatch is shown; press priorities and scope
        tbl_b.push_back(mk("bg_m2",       B_MD, 0, 2, 0, 0, 8, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("bg_m3",       B_MD, 0, 3, 0, 0, 8, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("bg_m0",       B_MD, 0, 0, 0, 0, 8, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("bg_load2",    B_SS, 2, 0, 2, 1, 8, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("bg_to_sw",    B_MD, 0, 1, 2, 1, 8, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("bg_t1",       B_TK, 0, 1, 1, 1, 9, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("bg_ring",     B_TK, 0, 1, 0, 0, 10, 1, 7, 0, 1, 2));
        tbl_b.push_back(mk("silence_ss",  B_SS, 0, 1, 0, 0, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("sc_m2",       B_MD, 0, 2, 0, 0, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("sc_ss_ign",   B_SS, 0, 2, 0, 0, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("sc_sr_ign",   B_SR, 0, 2, 0, 0, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("sc_m3",       B_MD, 0, 3, 0, 0, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("sc_m0",       B_MD, 0, 0, 0, 0, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("ss_md_same",  B_SS | B_MD, 5, 0, 5, 1, 10, 1, 7, 0, 0, 2));
        tbl_b.push_back(mk("sr_md_same",  B_SR | B_MD, 0, 0, 0, 0, 10, 1, 7, 0, 0, 2));

        repeat (3) @(posedge clockSignal);
        #1;
        check_zero("reset");
        @(negedge clockSignal);
        resetN = 1'b1;

        for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i]);

        #2;
        resetN = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clockSignal);
        resetN = 1'b1;

        for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_mode_controller.md
Name: timer_mode_controller

Overview:
- Control/sequencing block for the 100 Hz timekeeping datapath.
- Decodes user button pulses into the current mode: timer, stopwatch, viewClockAndDate, setAlarm.
- Runs the countdown-timer FSM and the stopwatch FSM, buffers stopwatch laps, and drives ringSound.
- Sits between the button conditioning logic and the display/time-of-day datapath.

Parameters:
- CW, 32: width in bits of every centisecond count (countdown, stopwatch, laps).
- LAP_DEPTH, 8: lap buffer entries; must be a power of two, 2..64.
- RING_TICKS, 3000: ticks of ringing before auto-silence (30 s at 100 Hz).

Ports:
- clockSignal  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- tickEnable  in  1  one-cycle pulse, 100 Hz (1 centisecond).
- modePress  in  1  one-cycle pulse, already debounced.
- startStopPress  in  1  one-cycle pulse, already debounced.
- splitResetPress  in  1  one-cycle pulse, already debounced.
- presetCentis  in  CW  countdown preset, sampled at start.
- lapRead  in  1  pop the lap buffer head.
- mode  out  2  00 timer, 01 stopwatch, 10 viewClockAndDate, 11 setAlarm.
- countdownValue  out  CW  remaining centiseconds.
- countdownRunning  out  1  countdown FSM is in RUN.
- stopwatchValue  out  CW  elapsed centiseconds.
- stopwatchRunning  out  1  stopwatch is running.
- lapData  out  CW  lap buffer head; valid when lapCount > 0.
- lapCount  out  $clog2(LAP_DEPTH)+1  entries currently held.
- lapOverflow  out  1  sticky: a lap was dropped.
- ringSound  out  1  alarm output.

Behaviour:
- Reset (resetN low, asynchronous): every output and all internal state go to 0; mode=00; both FSMs idle. Outputs are registered.
- Mode: modePress increments mode modulo 4 (11 wraps to 00). Counters keep running in the background across mode changes.
- Button scope: startStopPress and splitResetPress act only in mode 00 (countdown) or mode 01 (stopwatch). In modes 10/11 they are ignored.
- Same-cycle presses: only one press acts. Priority is startStop > splitReset > mode; lower-priority presses are dropped.
- Ringing silence: while ringSound=1, any press in any mode only clears ringing and is consumed. This takes priority over all other press handling.
- Countdown FSM states: IDLE, RUN, PAUSE, RINGING.
  - IDLE + startStop: if presetCentis != 0, load it and go to RUN; if 0, stay in IDLE.
  - RUN + tick: decrement. A tick at value 1 sets value to 0, goes to RINGING and sets ringSound=1 in the same edge.
  - RUN + startStop: go to PAUSE.
  - PAUSE + startStop: go to RUN.
  - RUN/PAUSE + splitReset: go to IDLE; value=0.
  - RINGING: a press, or RING_TICKS ticks counted from entry, returns to IDLE with ringSound=0.
- Stopwatch FSM states: STOPPED, RUNNING.
  - startStop toggles the state.
  - RUNNING + tick: increment; saturates at 2^CW-1.
  - RUNNING + splitReset: push stopwatchValue to the lap buffer.
  - STOPPED + splitReset: clear stopwatchValue, the lap buffer and lapOverflow.
- Tick/press same cycle: the tick is evaluated against the pre-edge state.
  - RUN + startStop + tick: decrements, then goes to PAUSE.
  - PAUSE + startStop + tick: no decrement.
  - A lap captured on a tick cycle stores the pre-increment value.
- Lap buffer: FIFO.
  - A push updates lapCount on the next cycle.
  - Push when full: entry dropped, contents unchanged, lapOverflow=1.
  - lapRead with lapCount=0: ignored.
  - Push and lapRead in the same cycle when full: both succeed.
- Latency: every effect is visible one clock after the causing pulse or tick edge.

Decomposition:
- Shared package timer_pkg:
  - mode encodings (timer, stopwatch, viewClockAndDate, setAlarm);
  - countdown state enum;
  - stopwatch state enum;
  - default CW.
- One sub-module, lap_fifo: parameterised by CW and LAP_DEPTH; ports push, pop, data in/out, count, full, empty.

Test Plan:
- Reset, then 5 modePress pulses: mode sequence 01,10,11,00,01. Assert resetN low mid-run: all outputs 0 asynchronously.
- mode 00, presetCentis=3, startStop, then 3 ticks: countdownValue 3→2→1→0; ringSound=1 at the third tick. Apply 3000 more ticks: ringSound=0, FSM in IDLE.
- mode 00, preset=100, start, 10 ticks, startStop: value 90 holds through 5 ticks. startStop+tick in the same cycle: value still 90 and running. Then splitReset: value 0.
- mode 01, start, 7 ticks, splitReset on the 8th tick cycle: lapData=7, lapCount=1. Apply 9 more splitResets with LAP_DEPTH=8: lapCount=8, lapOverflow=1.
- Stopwatch stopped with 4 laps: lapRead ×5 pops in FIFO order; the 5th is ignored and lapCount stays 0. splitReset clears the counter and lapOverflow.
- During ringing in mode 01, press startStop: ringing cleared, stopwatchRunning unchanged. startStop+modePress in the same cycle in mode 00: only startStop acts, mode unchanged.
